// File: rtl/pixel_buff_dp_if.sv
// pixel_buff_dp_if
// Bus bundle between a pixel producer/consumer and the pixel_buff_dp buffer.
//   master : drives writes, reads and scan control; receives pixel outputs
//   slave  : the buffer side
// Signals:
//   we, waddr, wdata       write port (wdata low 3*CH_W bits stored)
//   re, raddr, scan_start  read request, explicit address, scan-out (re)start
//   R, G, B, rvalid        unpacked pixel of the last completed read
//   frame_end              current rvalid carries the last pixel of a scan
//   scanning               buffer is in scan-out mode
//   err                    one-cycle pulse on an out-of-range access
interface pixel_buff_dp_if #(
    parameter int CH_W    = 8,
    parameter int ADDR_W  = 20,
    parameter int WDATA_W = 32
);
    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [WDATA_W-1:0] wdata;
    logic               re;
    logic [ADDR_W-1:0]  raddr;
    logic               scan_start;
    logic [CH_W-1:0]    R;
    logic [CH_W-1:0]    G;
    logic [CH_W-1:0]    B;
    logic               rvalid;
    logic               frame_end;
    logic               scanning;
    logic               err;

    modport master (
        output we, waddr, wdata, re, raddr, scan_start,
        input  R, G, B, rvalid, frame_end, scanning, err
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, scan_start,
        output R, G, B, rvalid, frame_end, scanning, err
    );
endinterface

// File: rtl/pixel_buff_dp.sv
// pixel_buff_dp
// Single-clock RGB frame/tile buffer of DEPTH pixels (3 x CH_W bits each) with
// independent write and read ports, explicit-address reads and a scan-out
// pointer for the display pipeline.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-low
//   bus    pixel_buff_dp_if.slave (write port, read port, scan control,
//          R/G/B/rvalid/frame_end/scanning/err outputs)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | reads use raddr; scan_start enters SCAN with ptr = 0
// SCAN  | reads use ptr; ptr advances per accepted read, wraps at DEPTH-1
module pixel_buff_dp #(
    parameter int CH_W      = 8,
    parameter int DEPTH     = 10000,
    parameter int ADDR_W    = 20,
    parameter int WDATA_W   = 32,
    parameter int CH_ORDER  = 0,
    parameter int SCAN_CONT = 1
) (
    input  logic          clk,
    input  logic          reset,
    pixel_buff_dp_if.slave bus
);
    localparam int PIX_W = 3 * CH_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [PIX_W-1:0]  mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [PIX_W-1:0]  rd_word;
    logic              rd_v;
    logic              rd_fe;

    logic              w_ok;
    logic              w_bad;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic              rd_acc;
    logic              rd_bad;
    logic              at_last;

    assign w_ok        = bus.we && ({1'b0, bus.waddr} < DEPTH_X);
    assign w_bad       = bus.we && !w_ok;
    assign rd_addr     = (state == SCAN) ? ptr : bus.raddr;
    // ptr never leaves [0, DEPTH-1], so a range miss can only happen in IDLE
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign rd_acc      = bus.re && rd_in_range;
    assign rd_bad      = bus.re && !rd_in_range;
    assign at_last     = (ptr == LAST_PTR);

    // Storage and read stage have no reset so the array can map onto block RAM.
    // The read samples the array before this edge's write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (w_ok) begin
            mem[bus.waddr[IDX_W-1:0]] <= bus.wdata[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            rd_word <= mem[rd_addr[IDX_W-1:0]];
        end
    end

    logic [CH_W-1:0] f_lo, f_mid, f_hi;
    logic [CH_W-1:0] un_r, un_g, un_b;

    assign f_lo  = rd_word[CH_W-1:0];
    assign f_mid = rd_word[2*CH_W-1:CH_W];
    assign f_hi  = rd_word[3*CH_W-1:2*CH_W];
    assign un_r  = f_lo;
    assign un_g  = (CH_ORDER == 1) ? f_mid : f_hi;
    assign un_b  = (CH_ORDER == 1) ? f_hi  : f_mid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            rd_v          <= 1'b0;
            rd_fe         <= 1'b0;
            bus.R         <= '0;
            bus.G         <= '0;
            bus.B         <= '0;
            bus.rvalid    <= 1'b0;
            bus.frame_end <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            rd_v          <= rd_acc;
            rd_fe         <= rd_acc && (state == SCAN) && at_last;
            bus.rvalid    <= rd_v;
            bus.frame_end <= rd_fe;
            // write and read errors in the same cycle merge into one pulse
            bus.err       <= w_bad || rd_bad;
            if (rd_v) begin
                bus.R <= un_r;
                bus.G <= un_g;
                bus.B <= un_b;
            end
            case (state)
                IDLE: begin
                    if (bus.scan_start) begin
                        state <= SCAN;
                        ptr   <= '0;
                    end
                end
                SCAN: begin
                    // restart wins over advance; a read in this cycle used the old ptr
                    if (bus.scan_start) begin
                        ptr <= '0;
                    end else if (bus.re) begin
                        if (at_last) begin
                            ptr <= '0;
                            if (SCAN_CONT == 0) begin
                                state <= IDLE;
                            end
                        end else begin
                            ptr <= ptr + ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.scanning = (state == SCAN);

    generate
        if (WDATA_W > PIX_W) begin : g_wdata_spare
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus.wdata[WDATA_W-1:PIX_W];
        end
    endgenerate
endmodule

// File: tb/tb_pixel_buff_dp.sv
`timescale 1ns/1ps
module tb_pixel_buff_dp;
    localparam int CW = 8;
    localparam int D  = 16;
    localparam int AW = 20;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference memory: plain array of stored 24-bit words
    logic [23:0] ref_mem [D];
    logic [23:0] last_word;

    pixel_buff_dp_if #(.CH_W(CW), .ADDR_W(AW), .WDATA_W(WW)) bus_a ();
    pixel_buff_dp_if #(.CH_W(CW), .ADDR_W(AW), .WDATA_W(WW)) bus_b ();

    pixel_buff_dp #(.CH_W(CW), .DEPTH(D), .ADDR_W(AW), .WDATA_W(WW),
                    .CH_ORDER(0), .SCAN_CONT(1))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    pixel_buff_dp #(.CH_W(CW), .DEPTH(D), .ADDR_W(AW), .WDATA_W(WW),
                    .CH_ORDER(1), .SCAN_CONT(0))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // expected {R,G,B} for a stored word under a channel order
    function automatic logic [23:0] rgb_of(input logic [23:0] w, input int order);
        if (order == 1) return {w[7:0], w[15:8], w[23:16]};
        return {w[7:0], w[23:16], w[15:8]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0;
        bus_a.re = 1'b0; bus_a.raddr = '0; bus_a.scan_start = 1'b0;
        bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0;
        bus_b.re = 1'b0; bus_b.raddr = '0; bus_b.scan_start = 1'b0;
    endtask

    task automatic write_both(input int addr, input logic [31:0] data);
        bus_a.we = 1'b1; bus_a.waddr = AW'(addr); bus_a.wdata = data;
        bus_b.we = 1'b1; bus_b.waddr = AW'(addr); bus_b.wdata = data;
        tick();
        bus_a.we = 1'b0; bus_b.we = 1'b0;
        if (addr < D) ref_mem[addr] = data[23:0];
    endtask

    task automatic read_both(input int addr);
        bus_a.re = 1'b1; bus_a.raddr = AW'(addr);
        bus_b.re = 1'b1; bus_b.raddr = AW'(addr);
        tick();
        bus_a.re = 1'b0; bus_b.re = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_a.we = 'x; bus_a.waddr = 'x; bus_a.wdata = 'x;
        bus_a.re = 'x; bus_a.raddr = 'x; bus_a.scan_start = 'x;
        bus_b.we = 'x; bus_b.waddr = 'x; bus_b.wdata = 'x;
        bus_b.re = 'x; bus_b.raddr = 'x; bus_b.scan_start = 'x;
        repeat (3) tick();
        total++;
        if ({bus_a.R, bus_a.G, bus_a.B, bus_a.rvalid, bus_a.frame_end, bus_a.scanning, bus_a.err} !== 28'h0) begin
            bad++;
            $display("FAIL reset_a: got %h want 0", {bus_a.R, bus_a.G, bus_a.B, bus_a.rvalid, bus_a.frame_end, bus_a.scanning, bus_a.err});
        end
        total++;
        if ({bus_b.R, bus_b.G, bus_b.B, bus_b.rvalid, bus_b.frame_end, bus_b.scanning, bus_b.err} !== 28'h0) begin
            bad++;
            $display("FAIL reset_b: got %h want 0", {bus_b.R, bus_b.G, bus_b.B, bus_b.rvalid, bus_b.frame_end, bus_b.scanning, bus_b.err});
        end
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < D; i++) write_both(i, $urandom);
        write_both(5, 32'h00332211);
        read_both(5);
        total++;
        if (bus_a.rvalid !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency: rvalid got %b want 0 one edge after accept", bus_a.rvalid);
        end
        tick();
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {1'b1, 8'h11, 8'h33, 8'h22}) begin
            bad++;
            $display("FAIL basic_read_a: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {1'b1, 24'h113322});
        end
        total++;
        if ({bus_b.rvalid, bus_b.R, bus_b.G, bus_b.B} !== {1'b1, 8'h11, 8'h22, 8'h33}) begin
            bad++;
            $display("FAIL basic_read_b: got %h want %h", {bus_b.rvalid, bus_b.R, bus_b.G, bus_b.B}, {1'b1, 24'h112233});
        end
        tick();
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {1'b0, 8'h11, 8'h33, 8'h22}) begin
            bad++;
            $display("FAIL basic_hold: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {1'b0, 24'h113322});
        end
        last_word = 24'h332211;
    endtask

    task automatic test_collision();
        write_both(3, 32'h00AABBCC);
        bus_a.we = 1'b1; bus_a.waddr = AW'(3); bus_a.wdata = 32'h00112233;
        bus_b.we = 1'b1; bus_b.waddr = AW'(3); bus_b.wdata = 32'h00112233;
        bus_a.re = 1'b1; bus_a.raddr = AW'(3);
        bus_b.re = 1'b1; bus_b.raddr = AW'(3);
        tick();
        ref_mem[3] = 24'h112233;
        bus_a.we = 1'b0; bus_b.we = 1'b0;
        tick();
        bus_a.re = 1'b0; bus_b.re = 1'b0;
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {1'b1, 8'hCC, 8'hAA, 8'hBB}) begin
            bad++;
            $display("FAIL collision_old_a: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {1'b1, 24'hCCAABB});
        end
        total++;
        if ({bus_b.rvalid, bus_b.R, bus_b.G, bus_b.B} !== {1'b1, 8'hCC, 8'hBB, 8'hAA}) begin
            bad++;
            $display("FAIL collision_old_b: got %h want %h", {bus_b.rvalid, bus_b.R, bus_b.G, bus_b.B}, {1'b1, 24'hCCBBAA});
        end
        tick();
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {1'b1, 8'h33, 8'h11, 8'h22}) begin
            bad++;
            $display("FAIL collision_new_a: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {1'b1, 24'h331122});
        end
        last_word = 24'h112233;
        tick();
    endtask

    task automatic test_back_to_back();
        logic        pv = 1'b0;
        logic [23:0] pw = '0;
        for (int c = 0; c <= 200; c++) begin
            logic        re_n, we_n;
            int          ra, wa;
            logic [31:0] wd;
            logic [23:0] acc_word;
            re_n = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            we_n = (c < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
            ra = $urandom_range(0, D - 1);
            wa = $urandom_range(0, D - 1);
            wd = $urandom;
            bus_a.re = re_n; bus_a.raddr = AW'(ra); bus_a.we = we_n; bus_a.waddr = AW'(wa); bus_a.wdata = wd;
            bus_b.re = re_n; bus_b.raddr = AW'(ra); bus_b.we = we_n; bus_b.waddr = AW'(wa); bus_b.wdata = wd;
            acc_word = ref_mem[ra];
            if (we_n) ref_mem[wa] = wd[23:0];
            tick();
            if (pv) last_word = pw;
            total++;
            if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {pv, rgb_of(last_word, 0)}) begin
                bad++;
                $display("FAIL b2b_a cycle %0d: got %h want %h", c, {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {pv, rgb_of(last_word, 0)});
            end
            total++;
            if ({bus_b.rvalid, bus_b.R, bus_b.G, bus_b.B} !== {pv, rgb_of(last_word, 1)}) begin
                bad++;
                $display("FAIL b2b_b cycle %0d: got %h want %h", c, {bus_b.rvalid, bus_b.R, bus_b.G, bus_b.B}, {pv, rgb_of(last_word, 1)});
            end
            pv = re_n;
            pw = acc_word;
        end
        drive_idle();
        tick();
    endtask

    task automatic test_errors();
        write_both(D, ~{8'h00, ref_mem[0]});
        total++;
        if ({bus_a.err, bus_b.err} !== 2'b11) begin
            bad++;
            $display("FAIL werr_pulse: got %b want 11", {bus_a.err, bus_b.err});
        end
        tick();
        total++;
        if ({bus_a.err, bus_b.err} !== 2'b00) begin
            bad++;
            $display("FAIL werr_single: got %b want 00", {bus_a.err, bus_b.err});
        end
        read_both(0);
        tick();
        last_word = ref_mem[0];
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {1'b1, rgb_of(last_word, 0)}) begin
            bad++;
            $display("FAIL werr_mem_intact: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {1'b1, rgb_of(last_word, 0)});
        end
        read_both(20);
        total++;
        if ({bus_a.err, bus_a.rvalid, bus_b.err, bus_b.rvalid} !== 4'b1010) begin
            bad++;
            $display("FAIL rerr_pulse: got %b want 1010", {bus_a.err, bus_a.rvalid, bus_b.err, bus_b.rvalid});
        end
        tick();
        total++;
        if ({bus_a.err, bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {2'b00, rgb_of(last_word, 0)}) begin
            bad++;
            $display("FAIL rerr_hold: got %h want %h", {bus_a.err, bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {2'b00, rgb_of(last_word, 0)});
        end
        bus_a.we = 1'b1; bus_a.waddr = AW'(20'hFFFFF); bus_a.wdata = $urandom;
        bus_a.re = 1'b1; bus_a.raddr = AW'(D + 4);
        tick();
        drive_idle();
        total++;
        if (bus_a.err !== 1'b1) begin
            bad++;
            $display("FAIL both_err_pulse: got %b want 1", bus_a.err);
        end
        tick();
        total++;
        if ({bus_a.err, bus_a.rvalid} !== 2'b00) begin
            bad++;
            $display("FAIL both_err_single: got %b want 00", {bus_a.err, bus_a.rvalid});
        end
    endtask

    task automatic test_scan_wrap();
        int       m_ptr = 0;
        logic     m_scan = 1'b0;
        logic     pv = 1'b0;
        int       pr = 0;
        for (int i = 0; i < D; i++) write_both(i, i);
        for (int c = 0; c < 28; c++) begin
            logic ss, re_n, acc;
            int   acc_r;
            ss   = (c == 0) || (c == 22);
            re_n = (c >= 1 && c <= 20) || (c >= 22 && c <= 26);
            bus_a.scan_start = ss;
            bus_a.re = re_n;
            bus_a.raddr = AW'($urandom_range(0, D - 1));
            acc   = re_n && m_scan;
            acc_r = m_ptr;
            if (ss) begin
                m_scan = 1'b1;
                m_ptr = 0;
            end else if (acc) begin
                m_ptr = (m_ptr + 1) % D;
            end
            tick();
            total++;
            if ({bus_a.rvalid, bus_a.frame_end, bus_a.scanning} !== {pv, pv && (pr == D - 1), m_scan}) begin
                bad++;
                $display("FAIL scan_wrap_flags cycle %0d: got %b want %b", c, {bus_a.rvalid, bus_a.frame_end, bus_a.scanning}, {pv, pv && (pr == D - 1), m_scan});
            end
            if (pv) begin
                total++;
                if (bus_a.R !== 8'(pr)) begin
                    bad++;
                    $display("FAIL scan_wrap_data cycle %0d: got %0d want %0d", c, bus_a.R, pr);
                end
            end
            pv = acc;
            pr = acc_r;
        end
        drive_idle();
    endtask

    task automatic test_scan_single();
        int       m_ptr = 0;
        logic     m_scan = 1'b0;
        logic     pv = 1'b0;
        int       pr = 0;
        int       stalls = 0;
        for (int c = 0; c < 40; c++) begin
            logic ss, re_n, acc, stall_now;
            int   acc_r;
            ss = (c == 0);
            stall_now = m_scan && (m_ptr == 7) && (stalls < 2);
            if (stall_now && c > 0) stalls++;
            re_n = (c > 0) && m_scan && !stall_now;
            bus_b.scan_start = ss;
            bus_b.re = re_n;
            bus_b.raddr = AW'($urandom_range(0, D - 1));
            acc   = re_n && m_scan;
            acc_r = m_ptr;
            if (ss) begin
                m_scan = 1'b1;
                m_ptr = 0;
            end else if (acc) begin
                if (m_ptr == D - 1) begin
                    m_ptr = 0;
                    m_scan = 1'b0;
                end else begin
                    m_ptr++;
                end
            end
            tick();
            total++;
            if ({bus_b.rvalid, bus_b.frame_end, bus_b.scanning} !== {pv, pv && (pr == D - 1), m_scan}) begin
                bad++;
                $display("FAIL scan_single_flags cycle %0d: got %b want %b", c, {bus_b.rvalid, bus_b.frame_end, bus_b.scanning}, {pv, pv && (pr == D - 1), m_scan});
            end
            if (pv) begin
                total++;
                if ({bus_b.R, bus_b.G, bus_b.B} !== rgb_of(24'(pr), 1)) begin
                    bad++;
                    $display("FAIL scan_single_data cycle %0d: got %h want %h", c, {bus_b.R, bus_b.G, bus_b.B}, rgb_of(24'(pr), 1));
                end
            end
            pv = acc;
            pr = acc_r;
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_scan();
        bus_a.scan_start = 1'b1;
        tick();
        bus_a.scan_start = 1'b0;
        bus_a.re = 1'b1;
        repeat (9) tick();
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.scanning} !== {1'b1, 8'd7, 1'b1}) begin
            bad++;
            $display("FAIL midscan_pre: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.scanning}, {1'b1, 8'd7, 1'b1});
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({bus_a.R, bus_a.G, bus_a.B, bus_a.rvalid, bus_a.frame_end, bus_a.scanning, bus_a.err} !== 28'h0) begin
            bad++;
            $display("FAIL midscan_async: got %h want 0", {bus_a.R, bus_a.G, bus_a.B, bus_a.rvalid, bus_a.frame_end, bus_a.scanning, bus_a.err});
        end
        bus_a.re = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        total++;
        if (bus_a.scanning !== 1'b0) begin
            bad++;
            $display("FAIL midscan_idle: scanning got %b want 0", bus_a.scanning);
        end
        read_both(9);
        tick();
        total++;
        if ({bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B} !== {1'b1, rgb_of(ref_mem[9], 0)}) begin
            bad++;
            $display("FAIL midscan_mem: got %h want %h", {bus_a.rvalid, bus_a.R, bus_a.G, bus_a.B}, {1'b1, rgb_of(ref_mem[9], 0)});
        end
    endtask

    initial begin
        drive_idle();
        last_word = '0;
        test_reset();
        test_basic();
        test_collision();
        test_back_to_back();
        test_errors();
        test_scan_wrap();
        test_scan_single();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pixel_buff_dp.md
Name: pixel_buff_dp

Overview:
- Parametrised single-clock RGB pixel buffer that supersedes the fixed 10000x24 frame buffer.
- Holds one frame (or tile) of DEPTH pixels, each 3 channels x CH_W bits.
- Write and read ports are independent and may be active in the same cycle.
- Reads come either from an explicit address or from an internal scan-out pointer that feeds the display pipeline, with an end-of-frame pulse.

Parameters:
- CH_W, 8: bits per colour channel.
- DEPTH, 10000: number of pixel locations.
- ADDR_W, 20: width of waddr and raddr; must satisfy 2^ADDR_W >= DEPTH.
- WDATA_W, 32: write data width; must be >= 3*CH_W.
- CH_ORDER, 0: packing of each stored word, low to high bits. 0 = R,B,G. 1 = R,G,B.
- SCAN_CONT, 1: 1 = scan wraps continuously. 0 = scan stops after one frame.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- we, input, 1: write enable.
- waddr, input, ADDR_W: write address.
- wdata, input, WDATA_W: write data; only bits [3*CH_W-1:0] are stored.
- re, input, 1: read request.
- raddr, input, ADDR_W: read address; used only in IDLE.
- scan_start, input, 1: start or restart scan-out at address 0.
- R, output, CH_W: red channel of the last completed read.
- G, output, CH_W: green channel of the last completed read.
- B, output, CH_W: blue channel of the last completed read.
- rvalid, output, 1: R/G/B updated this cycle.
- frame_end, output, 1: the current rvalid carries pixel DEPTH-1 of a scan.
- scanning, output, 1: high while in SCAN.
- err, output, 1: one-cycle pulse on an out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous):
  - R, G, B, rvalid, frame_end, err, scanning and the scan pointer are all 0; state is IDLE.
  - Memory contents are not cleared.
  - Reset asserted mid-scan aborts the scan immediately.
- Write:
  - If we=1 and waddr<DEPTH, store wdata[3*CH_W-1:0] at waddr on the clock edge.
  - If waddr>=DEPTH, drop the write and assert err in the next cycle.
- Read latency: exactly 1 cycle.
  - A read accepted at edge N sets R/G/B and rvalid=1 after edge N+1.
  - With no accepted read, rvalid=0 and R/G/B hold their previous values.
- Channel unpack, with word = stored bits:
  - CH_ORDER=0: R=word[CH_W-1:0], B=word[2CH_W-1:CH_W], G=word[3CH_W-1:2CH_W].
  - CH_ORDER=1: R=low field, G=middle field, B=high field.
- Same-address read and write in the same cycle: the read returns the OLD data (read-before-write). The new data is visible on the next read.
- State machine:
  - IDLE:
    - A read is accepted when re=1 and raddr<DEPTH.
    - If re=1 and raddr>=DEPTH: no rvalid; err pulses next cycle.
    - scan_start=1 moves to SCAN with ptr=0.
  - SCAN (scanning=1; raddr ignored):
    - re=1 reads ptr and advances it next cycle; re=0 stalls with ptr held.
    - When ptr=DEPTH-1 is read, frame_end=1 together with that pixel's rvalid.
    - Then ptr wraps to 0.
    - If SCAN_CONT=0, the next state is IDLE; otherwise it stays in SCAN.
  - scan_start in SCAN: ptr restarts at 0 on the next edge. A read issued in that same cycle still uses the old ptr and completes normally.
- Error priority: err is a single pulse if a write error and a read error occur in the same cycle.
- Arithmetic:
  - The pointer is ADDR_W bits.
  - Wrap is at DEPTH-1, not at 2^ADDR_W.

Test Plan:
- Reset/basic, DEPTH=16, CH_ORDER=0: hold reset low with X inputs; all outputs 0. Write 0x00332211 to address 5, then read address 5 → one cycle later R=0x11, B=0x22, G=0x33, rvalid=1 for 1 cycle.
- Collision: memory[3]=0xAABBCC. In one cycle write 0x112233 to 3 and read 3 → read returns R=0xCC, B=0xBB, G=0xAA. The next read of 3 returns R=0x33, B=0x22, G=0x11.
- Scan wrap, DEPTH=16, SCAN_CONT=1: fill addr i with i. Pulse scan_start, hold re=1 for 20 cycles → R sequence 0..15,0..3; frame_end high only with R=15; scanning stays 1.
- Single-shot scan with stall, SCAN_CONT=0: scan with re low for 2 cycles at ptr=7 → rvalid gaps of 2 cycles; data resumes at R=7; after R=15 with frame_end, scanning=0.
- Range errors, DEPTH=16: write to 16 → err pulse and memory unchanged. Read raddr=20 in IDLE → err=1, rvalid=0, R/G/B hold.
- Async reset mid-scan: assert reset between edges at ptr=9 → outputs 0 immediately. Release reset and read addr 9 → previously written data intact.
